// File: rtl/jogo_pkg.sv
// jogo_pkg: constants shared by the memory game.
// Holds the state codes shown on db_estado, the LFSR tap mask for
// x^8+x^6+x^5+x^4+1 and the seed used when semente is zero. It also has
// two small helpers: one advances the LFSR, the other applies the seed rule.
package jogo_pkg;

    localparam logic [4:0] EST_INICIAL     = 5'd0;
    localparam logic [4:0] EST_PREPARA     = 5'd1;
    localparam logic [4:0] EST_GERA        = 5'd2;
    localparam logic [4:0] EST_MOSTRA      = 5'd3;
    localparam logic [4:0] EST_APAGA       = 5'd4;
    localparam logic [4:0] EST_ESPERA      = 5'd5;
    localparam logic [4:0] EST_REGISTRA    = 5'd6;
    localparam logic [4:0] EST_COMPARA     = 5'd7;
    localparam logic [4:0] EST_PROXIMA     = 5'd8;
    localparam logic [4:0] EST_FIM_ACERTO  = 5'd9;
    localparam logic [4:0] EST_FIM_ERRO    = 5'd10;
    localparam logic [4:0] EST_FIM_TIMEOUT = 5'd11;

    // Fibonacci form, shifting left: the feedback is the XOR of bits 7,5,4,3.
    // These bits correspond to the x^8, x^6, x^5 and x^4 terms.
    localparam logic [7:0] LFSR_TAPS           = 8'hB8;
    localparam logic [7:0] LFSR_SEMENTE_PADRAO = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR would stay stuck at zero, so a zero seed is replaced.
    function automatic logic [7:0] lfsr_carga(input logic [7:0] s);
        return (s == 8'h00) ? LFSR_SEMENTE_PADRAO : s;
    endfunction

endpackage

// File: rtl/contador_param.sv
// contador_param: counter with a modulus, a synchronous clear and an enable.
// Ports: clock, reset (async, active-high), clr (sync clear, takes priority
//        over en), en (count enable), q (count value), fim (high while q == M-1).
// When the count is enabled at M-1, it wraps to zero.
module contador_param #(
    parameter int W = 4,
    parameter int M = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         fim
);

    localparam logic [W-1:0] Q_MAX = W'(M - 1);

    assign fim = (q == Q_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= fim ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: a "Genius"-style memory game.
// Each round adds one pseudo-random item to the sequence. The whole sequence
// is shown on the LEDs, then the player repeats it on the buttons.
// Ports: clock, reset (async, active-high); jogar (start request);
//        botoes (buttons, already synchronised); nivel (0 = PROF/2 rounds,
//        1 = PROF rounds); semente (LFSR seed); leds (shows the item during
//        display and echoes the buttons while waiting for a move);
//        ganhou/perdeu/timeout/pronto (result flags); db_estado, db_limite,
//        db_contagem (state code, current round limit, current position).
module jogo_memoria_param
    import jogo_pkg::*;
#(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16,
    parameter int T_MOSTRA = 1000,
    parameter int T_LIMITE = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    jogar,
    input  logic [N_BOTOES-1:0]     botoes,
    input  logic                    nivel,
    input  logic [7:0]              semente,
    output logic [N_BOTOES-1:0]     leds,
    output logic                    ganhou,
    output logic                    perdeu,
    output logic                    timeout,
    output logic                    pronto,
    output logic [4:0]              db_estado,
    output logic [$clog2(PROF)-1:0] db_limite,
    output logic [$clog2(PROF)-1:0] db_contagem
);

    localparam int IW = $clog2(N_BOTOES);
    localparam int PW = $clog2(PROF);
    // A single timer serves all phases. T_MOSTRA must not exceed T_LIMITE,
    // otherwise the timer wraps before the display phase ends.
    localparam int TW = $clog2(T_LIMITE);

    localparam logic [TW-1:0]       T_MOSTRA_FIM = TW'(T_MOSTRA - 1);
    localparam logic [TW-1:0]       T_APAGA_FIM  = TW'(T_MOSTRA / 2 - 1);
    localparam logic [PW-1:0]       FIM_CURTO    = PW'(PROF / 2 - 1);
    localparam logic [N_BOTOES-1:0] UM           = N_BOTOES'(1);

    logic [4:0]          estado, estado_prox;
    logic [7:0]          lfsr;
    logic                nivel_r;
    logic                algum_ant;
    logic [N_BOTOES-1:0] jogada;
    logic                acerto;
    logic [IW-1:0]       mem [PROF];

    logic [TW-1:0] timer_q;
    logic [PW-1:0] contagem, limite;
    logic          timer_fim, cont_fim, lim_fim;
    logic          timer_clr, timer_en, cont_clr, cont_en, lim_clr, lim_en;

    logic                algum, borda, ultimo, fim_jogo, terminal, inicio;
    logic [IW-1:0]       item_novo, item_atual;
    logic [N_BOTOES-1:0] alvo;

    assign algum      = |botoes;
    // A move is the rising edge of "any button". If a button is still held
    // from earlier, it must be released before it can count again.
    assign borda      = algum & ~algum_ant;
    assign item_novo  = IW'(lfsr % 8'(N_BOTOES));
    assign item_atual = mem[contagem];
    assign alvo       = UM << item_atual;
    // contagem never passes limite, so contagem == PROF-1 is also the last position.
    assign ultimo     = cont_fim || (contagem == limite);
    assign fim_jogo   = nivel_r ? lim_fim : (limite == FIM_CURTO);
    assign terminal   = (estado == EST_FIM_ACERTO) || (estado == EST_FIM_ERRO) ||
                        (estado == EST_FIM_TIMEOUT);
    assign inicio     = jogar && ((estado == EST_INICIAL) || terminal);

    always_comb begin
        estado_prox = estado;
        case (estado)
            EST_INICIAL:  if (jogar) estado_prox = EST_PREPARA;
            EST_PREPARA:  estado_prox = EST_GERA;
            EST_GERA:     estado_prox = EST_MOSTRA;
            EST_MOSTRA:   if (timer_q == T_MOSTRA_FIM) estado_prox = EST_APAGA;
            EST_APAGA:    if (timer_q == T_APAGA_FIM)
                              estado_prox = ultimo ? EST_ESPERA : EST_MOSTRA;
            // If a move arrives in the same cycle as the timeout, the move is taken.
            EST_ESPERA:   if (borda)          estado_prox = EST_REGISTRA;
                          else if (timer_fim) estado_prox = EST_FIM_TIMEOUT;
            EST_REGISTRA: estado_prox = EST_COMPARA;
            EST_COMPARA:  if (!acerto)        estado_prox = EST_FIM_ERRO;
                          else if (!ultimo)   estado_prox = EST_ESPERA;
                          else if (fim_jogo)  estado_prox = EST_FIM_ACERTO;
                          else                estado_prox = EST_PROXIMA;
            EST_PROXIMA:  estado_prox = EST_GERA;
            EST_FIM_ACERTO, EST_FIM_ERRO, EST_FIM_TIMEOUT:
                          if (jogar) estado_prox = EST_PREPARA;
            default:      estado_prox = EST_INICIAL;
        endcase
    end

    // The timer restarts on every state change. It only runs in the timed phases.
    assign timer_clr = (estado_prox != estado);
    assign timer_en  = (estado == EST_MOSTRA) || (estado == EST_APAGA) ||
                       (estado == EST_ESPERA);
    assign cont_clr  = (estado == EST_PREPARA) || (estado == EST_GERA) ||
                       (estado == EST_PROXIMA) ||
                       ((estado == EST_APAGA) && (estado_prox == EST_ESPERA));
    assign cont_en   = ((estado == EST_APAGA) && (estado_prox == EST_MOSTRA)) ||
                       ((estado == EST_COMPARA) && (estado_prox == EST_ESPERA));
    assign lim_clr   = (estado == EST_PREPARA);
    assign lim_en    = (estado == EST_PROXIMA);

    contador_param #(.W(TW), .M(T_LIMITE)) u_timer (
        .clock(clock), .reset(reset), .clr(timer_clr), .en(timer_en),
        .q(timer_q), .fim(timer_fim)
    );

    contador_param #(.W(PW), .M(PROF)) u_contagem (
        .clock(clock), .reset(reset), .clr(cont_clr), .en(cont_en),
        .q(contagem), .fim(cont_fim)
    );

    contador_param #(.W(PW), .M(PROF)) u_limite (
        .clock(clock), .reset(reset), .clr(lim_clr), .en(lim_en),
        .q(limite), .fim(lim_fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= EST_INICIAL;
            lfsr      <= LFSR_SEMENTE_PADRAO;
            nivel_r   <= 1'b0;
            algum_ant <= 1'b0;
            jogada    <= '0;
            acerto    <= 1'b0;
        end else begin
            estado    <= estado_prox;
            algum_ant <= algum;
            if (inicio) begin
                lfsr    <= lfsr_carga(semente);
                nivel_r <= nivel;
            end else if (estado == EST_GERA) begin
                lfsr <= lfsr_next(lfsr);
            end
            if ((estado == EST_ESPERA) && borda) jogada <= botoes;
            // A press of several buttons can never equal a one-hot target.
            if (estado == EST_REGISTRA) acerto <= (jogada == alvo);
        end
    end

    // The sequence memory has no reset. Its contents only matter after GERA writes them.
    always_ff @(posedge clock) begin
        if (estado == EST_GERA) mem[limite] <= item_novo;
    end

    always_comb begin
        leds = '0;
        case (estado)
            EST_MOSTRA:                             leds = alvo;
            EST_ESPERA, EST_REGISTRA, EST_COMPARA:  leds = botoes;
            default:                                leds = '0;
        endcase
    end

    assign ganhou      = (estado == EST_FIM_ACERTO);
    assign perdeu      = (estado == EST_FIM_ERRO);
    assign timeout     = (estado == EST_FIM_TIMEOUT);
    assign pronto      = terminal;
    assign db_estado   = estado;
    assign db_limite   = limite;
    assign db_contagem = contagem;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb_jogo_memoria_param: directed and random scenarios on two instances of
// the game. A 4-button/16-deep instance covers most behaviour. An
// 8-button/32-deep instance plays a full-length game. The display times are
// shortened to keep the run short.
module tb_jogo_memoria_param;

    localparam int A_N = 4, A_P = 16, A_TM = 4, A_TL = 40;
    localparam int B_N = 8, B_P = 32, B_TM = 2, B_TL = 30;

    localparam int E_INICIAL = 0, E_PREPARA = 1, E_MOSTRA = 3, E_ESPERA = 5;
    localparam int E_REGISTRA = 6, E_COMPARA = 7, E_PROXIMA = 8;
    localparam int E_ACERTO = 9, E_ERRO = 10, E_TIMEOUT = 11;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT A ----------------
    logic       jogar_a = 1'b0, nivel_a = 1'b0;
    logic [3:0] botoes_a = '0;
    logic [7:0] semente_a = '0;
    logic [3:0] leds_a, db_limite_a, db_contagem_a;
    logic [4:0] db_estado_a;
    logic       ganhou_a, perdeu_a, timeout_a, pronto_a;

    jogo_memoria_param #(.N_BOTOES(A_N), .PROF(A_P), .T_MOSTRA(A_TM), .T_LIMITE(A_TL)) dut_a (
        .clock(clock), .reset(reset), .jogar(jogar_a), .botoes(botoes_a), .nivel(nivel_a),
        .semente(semente_a), .leds(leds_a), .ganhou(ganhou_a), .perdeu(perdeu_a),
        .timeout(timeout_a), .pronto(pronto_a), .db_estado(db_estado_a),
        .db_limite(db_limite_a), .db_contagem(db_contagem_a)
    );

    // ---------------- DUT B ----------------
    logic       jogar_b = 1'b0, nivel_b = 1'b0;
    logic [7:0] botoes_b = '0;
    logic [7:0] semente_b = '0;
    logic [7:0] leds_b;
    logic [4:0] db_limite_b, db_contagem_b, db_estado_b;
    logic       ganhou_b, perdeu_b, timeout_b, pronto_b;

    jogo_memoria_param #(.N_BOTOES(B_N), .PROF(B_P), .T_MOSTRA(B_TM), .T_LIMITE(B_TL)) dut_b (
        .clock(clock), .reset(reset), .jogar(jogar_b), .botoes(botoes_b), .nivel(nivel_b),
        .semente(semente_b), .leds(leds_b), .ganhou(ganhou_b), .perdeu(perdeu_b),
        .timeout(timeout_b), .pronto(pronto_b), .db_estado(db_estado_b),
        .db_limite(db_limite_b), .db_contagem(db_contagem_b)
    );

    // ---------------- observation mux ----------------
    int         sel = 0;
    int         cur_n = A_N, cur_p = A_P, cur_tm = A_TM, cur_tl = A_TL;
    logic [7:0] obs_leds;
    logic [4:0] obs_estado, obs_lim, obs_cont;
    logic       obs_g, obs_p, obs_t, obs_pr;

    always_comb begin
        if (sel == 0) begin
            obs_leds = {4'b0, leds_a};       obs_estado = db_estado_a;
            obs_lim  = {1'b0, db_limite_a};  obs_cont   = {1'b0, db_contagem_a};
            obs_g = ganhou_a; obs_p = perdeu_a; obs_t = timeout_a; obs_pr = pronto_a;
        end else begin
            obs_leds = leds_b;               obs_estado = db_estado_b;
            obs_lim  = db_limite_b;          obs_cont   = db_contagem_b;
            obs_g = ganhou_b; obs_p = perdeu_b; obs_t = timeout_b; obs_pr = pronto_b;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_seq [32];
    logic [31:0] exp_q [$];

    // The sequence comes straight from the stated rule. The LFSR is taken
    // mod the button count, and the taps are the polynomial x^8+x^6+x^5+x^4+1.
    function automatic void build_seq(input logic [7:0] seed, input int nb);
        int l;
        l = (seed == 8'h00) ? 1 : int'(seed);
        for (int i = 0; i < 32; i++) begin
            exp_seq[i] = l % nb;
            l = (l * 2 + ($countones(l & 'hB8) % 2)) % 256;
        end
    endfunction

    function automatic logic [31:0] oh(input int idx);
        return 32'(1) << idx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input int g, input int p, input int t);
        check({tag, "_ganhou"},  32'(obs_g),  g);
        check({tag, "_perdeu"},  32'(obs_p),  p);
        check({tag, "_timeout"}, 32'(obs_t),  t);
        check({tag, "_pronto"},  32'(obs_pr), (g | p | t));
    endtask

    // ---------------- driver tasks ----------------
    task automatic select_dut(input int s);
        sel = s;
        if (s == 0) begin cur_n = A_N; cur_p = A_P; cur_tm = A_TM; cur_tl = A_TL; end
        else        begin cur_n = B_N; cur_p = B_P; cur_tm = B_TM; cur_tl = B_TL; end
    endtask

    task automatic drive_botoes(input logic [7:0] b);
        if (sel == 0) botoes_a = b[3:0]; else botoes_b = b;
    endtask

    task automatic drive_nivel(input logic v);
        if (sel == 0) nivel_a = v; else nivel_b = v;
    endtask

    task automatic start_game(input logic [7:0] seed, input logic niv);
        @(negedge clock);
        if (sel == 0) begin semente_a = seed; nivel_a = niv; jogar_a = 1'b1; end
        else          begin semente_b = seed; nivel_b = niv; jogar_b = 1'b1; end
        @(negedge clock);
        if (sel == 0) jogar_a = 1'b0; else jogar_b = 1'b0;
        check("start_estado", 32'(obs_estado), E_PREPARA);
        check_flags("start", 0, 0, 0);
        build_seq(seed, cur_n);
    endtask

    task automatic wait_estado(input string tag, input int target, input int budget);
        bit hit;
        hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clock);
            if (int'(obs_estado) == target) hit = 1;
        end
        check(tag, 32'(hit), 1);
    endtask

    // Watches the display of items 0..k. It returns at the first cycle in espera.
    task automatic watch_show(input int k);
        int lit, dark, budget;
        bit seen, prev_lit, done;
        exp_q.delete();
        for (int i = 0; i <= k; i++) exp_q.push_back(oh(exp_seq[i]));
        lit = 0; dark = 0; seen = 0; prev_lit = 0; done = 0;
        budget = (k + 1) * cur_tm * 2 + 20;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clock);
            if (int'(obs_estado) == E_ESPERA) begin
                done = 1;
            end else if (obs_leds != 8'h00) begin
                if (!prev_lit) begin
                    if (exp_q.size() > 0)
                        check($sformatf("show_item_r%0d", k), 32'(obs_leds), exp_q.pop_front());
                    else
                        check("show_extra_item", 32'(obs_leds), 0);
                end
                lit++; seen = 1; prev_lit = 1;
            end else begin
                if (seen) dark++;
                prev_lit = 0;
            end
        end
        check($sformatf("show_reaches_espera_r%0d", k), 32'(done), 1);
        check("show_items_left", 32'(exp_q.size()), 0);
        check("show_lit_cycles", lit, (k + 1) * cur_tm);
        check("show_dark_cycles", dark, (k + 1) * (cur_tm / 2));
        check("show_limite", 32'(obs_lim), k);
        check("show_contagem", 32'(obs_cont), 0);
    endtask

    // This task starts at a negedge in espera and plays the correct item i of round k.
    task automatic play_move(input int i, input int k, input bit final_round);
        logic [31:0] b;
        b = oh(exp_seq[i]);
        drive_botoes(b[7:0]);
        #1 check("echo_leds", 32'(obs_leds), b);
        @(negedge clock);
        check("move_registra", 32'(obs_estado), E_REGISTRA);
        drive_botoes(8'h00);
        @(negedge clock);
        check("move_compara", 32'(obs_estado), E_COMPARA);
        @(negedge clock);
        if (i < k) begin
            check("move_back_espera", 32'(obs_estado), E_ESPERA);
            check("move_contagem", 32'(obs_cont), i + 1);
        end else if (final_round) begin
            check("move_fim_acerto", 32'(obs_estado), E_ACERTO);
        end else begin
            check("move_proxima", 32'(obs_estado), E_PROXIMA);
        end
    endtask

    task automatic play_full_game(input logic [7:0] seed, input logic niv, input bit flip_nivel);
        int fin;
        start_game(seed, niv);
        if (flip_nivel) drive_nivel(~niv);
        fin = niv ? cur_p - 1 : cur_p / 2 - 1;
        for (int r = 0; r <= fin; r++) begin
            watch_show(r);
            for (int i = 0; i <= r; i++) play_move(i, r, (r == fin));
        end
    endtask

    // ---------------- scenarios ----------------
    int          cnt;
    logic [31:0] tmp;
    logic [7:0]  seed;

    initial begin
        select_dut(0);
        repeat (3) @(negedge clock);
        check("rst_estado", 32'(obs_estado), E_INICIAL);
        check("rst_leds", 32'(obs_leds), 0);
        check("rst_limite", 32'(obs_lim), 0);
        check("rst_contagem", 32'(obs_cont), 0);
        check_flags("rst", 0, 0, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_estado", 32'(obs_estado), E_INICIAL);

        // Short game with seed 5A and every move correct. nivel is raised
        // mid-game and must not lengthen the game.
        play_full_game(8'h5A, 1'b0, 1'b1);
        check_flags("win_short", 1, 0, 0);
        check("win_short_limite", 32'(obs_lim), 7);
        check("win_short_leds", 32'(obs_leds), 0);
        drive_nivel(1'b0);

        // Restart from the win state. Round 2 starts with a button held over
        // from earlier. In round 3 the second move is wrong.
        seed = 8'($urandom_range(1, 255));
        start_game(seed, 1'b0);
        watch_show(0);
        play_move(0, 0, 0);
        tmp = oh(exp_seq[0]);
        drive_botoes(tmp[7:0]);
        watch_show(1);
        repeat (3) @(negedge clock);
        check("held_no_move_estado", 32'(obs_estado), E_ESPERA);
        check("held_no_move_contagem", 32'(obs_cont), 0);
        drive_botoes(8'h00);
        @(negedge clock);
        play_move(0, 1, 0);
        play_move(1, 1, 0);
        watch_show(2);
        play_move(0, 2, 0);
        tmp = oh((exp_seq[1] + 1) % cur_n);
        drive_botoes(tmp[7:0]);
        @(negedge clock);
        check("wrong_registra", 32'(obs_estado), E_REGISTRA);
        drive_botoes(8'h00);
        @(negedge clock);
        check("wrong_perdeu_not_yet", 32'(obs_p), 0);
        @(negedge clock);
        check("wrong_estado", 32'(obs_estado), E_ERRO);
        check_flags("wrong", 0, 1, 0);

        // Restart from the error state and make no move at all. The timeout
        // should come after exactly T_LIMITE cycles in espera.
        start_game(8'($urandom_range(0, 255)), 1'b0);
        watch_show(0);
        cnt = 1;
        for (int c = 0; c < cur_tl + 10; c++) begin
            @(negedge clock);
            if (int'(obs_estado) == E_ESPERA) cnt++;
            else break;
        end
        check("timeout_cycles", cnt, cur_tl);
        check("timeout_estado", 32'(obs_estado), E_TIMEOUT);
        check_flags("timeout", 0, 0, 1);

        // A move in the very last cycle of espera beats the timeout.
        start_game(8'($urandom_range(1, 255)), 1'b0);
        watch_show(0);
        repeat (cur_tl - 1) @(negedge clock);
        check("late_still_espera", 32'(obs_estado), E_ESPERA);
        tmp = oh(exp_seq[0]);
        drive_botoes(tmp[7:0]);
        @(negedge clock);
        check("late_move_wins", 32'(obs_estado), E_REGISTRA);
        drive_botoes(8'h00);
        repeat (2) @(negedge clock);
        check("late_move_proxima", 32'(obs_estado), E_PROXIMA);
        check("late_no_timeout", 32'(obs_t), 0);

        // Assert reset in the middle of the display. The effect must be immediate.
        wait_estado("reach_mostra", E_MOSTRA, 20);
        check("pre_rst_leds_on", 32'(obs_leds != 8'h00), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_leds", 32'(obs_leds), 0);
        check("async_rst_estado", 32'(obs_estado), E_INICIAL);
        check_flags("async_rst", 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("post_rst_estado", 32'(obs_estado), E_INICIAL);
        check_flags("post_rst", 0, 0, 0);

        // Press two buttons at once. This counts as an error.
        start_game(8'($urandom_range(1, 255)), 1'b0);
        watch_show(0);
        drive_botoes(8'h03);
        @(negedge clock);
        check("two_btn_registra", 32'(obs_estado), E_REGISTRA);
        drive_botoes(8'h00);
        repeat (2) @(negedge clock);
        check("two_btn_estado", 32'(obs_estado), E_ERRO);
        check_flags("two_btn", 0, 1, 0);

        // Full-length game on the 8-button, 32-deep instance with a zero seed.
        select_dut(1);
        play_full_game(8'h00, 1'b1, 1'b0);
        check_flags("win_full", 1, 0, 0);
        check("win_full_limite", 32'(obs_lim), 31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jogo_memoria_param.md
JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 Parameter N_BOTOES, default 4, number of buttons/LEDs (2..8).
REQ-002 Parameter PROF, default 16, maximum sequence length (2..32).
REQ-003 Parameter T_MOSTRA, default 1000, clock cycles each sequence item is lit.
REQ-004 Parameter T_LIMITE, default 5000, clock cycles allowed per player move before timeout.
REQ-005 clock  in  1  single system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 jogar  in  1  start request, level, sampled in inicial/final states.
REQ-008 botoes  in  N_BOTOES  raw button levels, already synchronised, active-high.
REQ-009 nivel  in  1  0 = short game (PROF/2 items), 1 = full game (PROF items).
REQ-010 semente  in  8  LFSR seed loaded on start.
REQ-011 leds  out  N_BOTOES  one-hot item display / echo of pressed button.
REQ-012 ganhou, perdeu, timeout  out  1 each  terminal result flags, held until next start.
REQ-013 pronto  out  1  high in any terminal state.
REQ-014 db_estado  out  5  current state code; db_limite, db_contagem  out  clog2(PROF) each  current round limit and position.

Function
REQ-015 On start (jogar=1 in inicial or terminal state) the block SHALL load the 8-bit LFSR (x^8+x^6+x^5+x^4+1) with semente (0 replaced by 8'h01), clear flags, set limite=0.
REQ-016 Each new round SHALL append one item to the internal sequence memory at address limite, item = LFSR mod N_BOTOES, then advance the LFSR one step.
REQ-017 Mostra phase: items 0..limite SHALL each drive leds one-hot for T_MOSTRA cycles, followed by T_MOSTRA/2 cycles of leds=0.
REQ-018 Espera phase: a move SHALL be the cycle in which botoes goes from all-zero to nonzero (edge detect on OR of botoes).
REQ-019 A move with exactly one bit set SHALL be registered and compared one cycle later against memory[contagem]; leds SHALL echo botoes while pressed.
REQ-020 A move with more than one bit set SHALL count as an error.
REQ-021 Correct move with contagem<limite: contagem+1, timer cleared, return to espera.
REQ-022 Correct move with contagem=limite: if limite=fim (PROF/2-1 or PROF-1 per nivel latched at start) go to fim_acerto, else limite+1, contagem=0, next round.
REQ-023 Wrong move: go to fim_erro; perdeu=1.
REQ-024 Timer counts while in espera; reaching T_LIMITE-1 without a move: fim_timeout; timeout=1, perdeu=0.
REQ-025 A move edge and timer expiry in the same cycle: the move SHALL win.
REQ-026 A held button at the start of espera SHALL NOT count until released and pressed again.
REQ-027 nivel SHALL be latched on start; changes mid-game ignored.
REQ-028 States: inicial, prepara, gera, mostra, apaga, espera, registra, compara, proxima, fim_acerto, fim_erro, fim_timeout; codes 0..11 on db_estado.
REQ-029 Terminal states SHALL hold flags and pronto=1; jogar returns to prepara in one cycle.

Reset
REQ-030 Reset SHALL force inicial, leds=0, all flags/pronto=0, counters and timer=0, LFSR=8'h01; memory contents undefined.
REQ-031 Reset mid-game SHALL abort immediately; no flag asserted afterwards until a new game ends.

Structure
REQ-032 State codes, LFSR polynomial and seed fallback constant SHALL live in shared package jogo_pkg.
REQ-033 One sub-module, contador_param (width, modulus, clear, enable, end flag), SHALL be instantiated for timer, position and limit counters.
REQ-034 Sequence memory SHALL be a PROF x clog2(N_BOTOES) register array, write in gera only.

Verification
REQ-035 Defaults, nivel=0, semente=8'h5A, player echoes every shown item -> ganhou=1 after 8 rounds, pronto=1, perdeu=0.
REQ-036 Round 3, wrong button on second move -> perdeu=1 next-but-one cycle, db_estado=10.
REQ-037 No press for 5000 cycles in espera -> timeout=1, perdeu=0, db_estado=11.
REQ-038 Two buttons pressed together (4'b0011) -> perdeu=1.
REQ-039 Reset asserted during mostra -> same edge leds=0, db_estado=0, flags 0.
REQ-040 N_BOTOES=8, PROF=32, nivel=1 full correct game -> 32 rounds, ganhou=1, db_limite=31.
